// File: rtl/mse_multi_pkg.sv
// Shared types, width helpers and the per-lane squared-difference function
// for the multi-lane MSE engine.
package mse_multi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Widest sample lane_sq_diff accepts; callers zero-extend narrower samples.
  localparam int unsigned SAMPLE_MAX_W = 32;

  // Lane-sum tree width: enough headroom that summing all lanes cannot overflow.
  function automatic int unsigned tree_width(input int unsigned acc_w, input int unsigned lanes);
    return acc_w + $clog2(lanes);
  endfunction

  // Width of the log2-divisor field for a given maximum band count.
  function automatic int unsigned band_shift_width(input int unsigned bands_max);
    return $clog2($clog2(bands_max) + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // |a-b|^2 on unsigned samples.
  function automatic logic [2*SAMPLE_MAX_W-1:0] lane_sq_diff(
    input logic [SAMPLE_MAX_W-1:0] a,
    input logic [SAMPLE_MAX_W-1:0] b
  );
    logic [SAMPLE_MAX_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (2*SAMPLE_MAX_W)'(d) * (2*SAMPLE_MAX_W)'(d);
  endfunction

endpackage

// File: rtl/mse_lane.sv
// One MSE lane: abs-diff, square, and saturating accumulate with
// load-on-start. DATA_WIDTH up to 32 bits.
module mse_lane
  import mse_multi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH_ACC = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH_ACC-1:0] acc
);

  localparam int unsigned SQ_W  = 2*SAMPLE_MAX_W;
  localparam int unsigned NXT_W = SQ_W + 1;
  localparam logic [DATA_WIDTH_ACC-1:0] ACC_MAX = '1;

  logic [SQ_W-1:0]  sq;
  logic [NXT_W-1:0] nxt;

  // Candidate accumulator value: square alone on a start element, else running sum.
  always_comb begin
    sq  = lane_sq_diff(SAMPLE_MAX_W'(a), SAMPLE_MAX_W'(b));
    nxt = (load ? '0 : NXT_W'(acc)) + NXT_W'(sq);
  end

  // Accumulator register, clamped at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (en)
      acc <= (nxt > NXT_W'(ACC_MAX)) ? ACC_MAX : nxt[DATA_WIDTH_ACC-1:0];
  end

endmodule

// File: rtl/mse_multi.sv
// Multi-lane mean-square-error engine: vector FSM, S0 input register,
// S1 lane accumulators, S2 adder tree, S3 shift/saturate, registered outputs.
// Optional build macro MSE_MULTI_ROUND_EN: round-half-up divide instead of truncate.
module mse_multi
  import mse_multi_pkg::*;
#(
  parameter  int unsigned WORD_WIDTH       = 64,
  parameter  int unsigned DATA_WIDTH       = 16,
  parameter  int unsigned DATA_WIDTH_ACC   = 48,
  parameter  int unsigned HSI_BANDS_MAX    = 256,
  parameter  int unsigned HSI_LIBRARY_SIZE = 256,
  localparam int unsigned LANES            = WORD_WIDTH / DATA_WIDTH,
  localparam int unsigned BAND_SHIFT_W     = band_shift_width(HSI_BANDS_MAX),
  localparam int unsigned REF_W            = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    element_valid,
  input  logic                    element_start,
  input  logic                    element_last,
  input  logic [WORD_WIDTH-1:0]   element_a,
  input  logic [WORD_WIDTH-1:0]   element_b,
  input  logic [REF_W-1:0]        vctr_ref,
  input  logic [BAND_SHIFT_W-1:0] band_shift,
  output logic                    mse_valid,
  output logic [WORD_WIDTH-1:0]   mse_value,
  output logic [REF_W-1:0]        mse_ref,
  output logic                    proto_err,
  output logic                    busy
);

  localparam int unsigned TREE_W = tree_width(DATA_WIDTH_ACC, LANES);
  localparam int unsigned EXT_W  = max_u(TREE_W + 1, WORD_WIDTH + 1);

  state_t                  state;
  logic [REF_W-1:0]        cur_ref;
  logic [BAND_SHIFT_W-1:0] cur_shift;
  logic                    accept;

  logic                    s0_v, s0_load, s0_launch;
  logic [WORD_WIDTH-1:0]   s0_a, s0_b;
  logic [REF_W-1:0]        s0_ref;
  logic [BAND_SHIFT_W-1:0] s0_shift;

  logic [DATA_WIDTH_ACC-1:0] lane_acc [LANES];

  logic                    s1_v;
  logic [REF_W-1:0]        s1_ref;
  logic [BAND_SHIFT_W-1:0] s1_shift;

  logic [TREE_W-1:0]       tree_sum;
  logic                    s2_v;
  logic [TREE_W-1:0]       s2_sum;
  logic [REF_W-1:0]        s2_ref;
  logic [BAND_SHIFT_W-1:0] s2_shift;

  logic [EXT_W-1:0]        rnd, quot;
  logic [WORD_WIDTH-1:0]   quot_sat;
  logic                    s3_v;
  logic [WORD_WIDTH-1:0]   s3_value;
  logic [REF_W-1:0]        s3_ref;

  // A start always opens a vector (aborting any open one); other elements need an open vector.
  assign accept = element_valid & (element_start | (state == ACTIVE));

  // Vector FSM, protocol error pulse, and S0 input register.
  // Ref/shift ride with each element so an abort-and-restart needs no extra bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ref   <= '0;
      cur_shift <= '0;
      proto_err <= 1'b0;
      s0_v      <= 1'b0;
      s0_load   <= 1'b0;
      s0_launch <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_ref    <= '0;
      s0_shift  <= '0;
    end else begin
      proto_err <= element_valid & (element_start == (state == ACTIVE));
      s0_v      <= accept;
      s0_load   <= element_start;
      s0_launch <= accept & element_last;
      if (accept) begin
        s0_a     <= element_a;
        s0_b     <= element_b;
        s0_ref   <= element_start ? vctr_ref : cur_ref;
        s0_shift <= element_start ? band_shift : cur_shift;
      end
      if (element_valid && element_start) begin
        cur_ref   <= vctr_ref;
        cur_shift <= band_shift;
      end
      case (state)
        IDLE:    if (element_valid && element_start && !element_last) state <= ACTIVE;
        ACTIVE:  if (element_valid && element_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mse_lane #(
      .DATA_WIDTH     (DATA_WIDTH),
      .DATA_WIDTH_ACC (DATA_WIDTH_ACC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (s0_v),
      .load  (s0_load),
      .a     (s0_a[g*DATA_WIDTH +: DATA_WIDTH]),
      .b     (s0_b[g*DATA_WIDTH +: DATA_WIDTH]),
      .acc   (lane_acc[g])
    );
  end

  // Result metadata travelling alongside the lane accumulate stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_ref   <= '0;
      s1_shift <= '0;
    end else begin
      s1_v <= s0_v & s0_launch;
      if (s0_v && s0_launch) begin
        s1_ref   <= s0_ref;
        s1_shift <= s0_shift;
      end
    end
  end

  // Lane reduction; width covers the worst case so no overflow is possible.
  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < LANES; i++)
      tree_sum = tree_sum + TREE_W'(lane_acc[i]);
  end

  // S2: registered tree sum, captured before a following start can reload the lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_sum   <= '0;
      s2_ref   <= '0;
      s2_shift <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum   <= tree_sum;
        s2_ref   <= s1_ref;
        s2_shift <= s1_shift;
      end
    end
  end

  // Power-of-two divide, optional half-up rounding, then clamp to the output word.
  always_comb begin
    rnd = '0;
`ifdef MSE_MULTI_ROUND_EN
    rnd = (EXT_W'(1) << s2_shift) >> 1;
`endif
    quot     = (EXT_W'(s2_sum) + rnd) >> s2_shift;
    quot_sat = (|quot[EXT_W-1:WORD_WIDTH]) ? '1 : quot[WORD_WIDTH-1:0];
  end

  // S3 shift/saturate register and the output register behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v      <= 1'b0;
      s3_value  <= '0;
      s3_ref    <= '0;
      mse_valid <= 1'b0;
      mse_value <= '0;
      mse_ref   <= '0;
    end else begin
      s3_v      <= s2_v;
      mse_valid <= s3_v;
      if (s2_v) begin
        s3_value <= quot_sat;
        s3_ref   <= s2_ref;
      end
      if (s3_v) begin
        mse_value <= s3_value;
        mse_ref   <= s3_ref;
      end
    end
  end

  assign busy = (state == ACTIVE) | s0_v | s1_v | s2_v | s3_v;

endmodule

// File: tb/tb_mse_multi.sv
// Self-checking bench for mse_multi: directed scenarios plus randomized
// vectors checked against an arithmetic reference model.
module tb_mse_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        element_valid = 1'b0, element_start = 1'b0, element_last = 1'b0;
  logic [63:0] element_a = '0, element_b = '0;
  logic [7:0]  vctr_ref = '0;
  logic [3:0]  band_shift = '0;

  logic        mse_valid, proto_err, busy;
  logic [63:0] mse_value;
  logic [7:0]  mse_ref;

  logic        s_valid, s_err, s_busy;
  logic [31:0] s_value;
  logic [7:0]  s_ref;

  always #5 clk = ~clk;

  mse_multi dut (
    .clk(clk), .rst_n(rst_n),
    .element_valid(element_valid), .element_start(element_start), .element_last(element_last),
    .element_a(element_a), .element_b(element_b),
    .vctr_ref(vctr_ref), .band_shift(band_shift),
    .mse_valid(mse_valid), .mse_value(mse_value), .mse_ref(mse_ref),
    .proto_err(proto_err), .busy(busy)
  );

  mse_multi #(
    .WORD_WIDTH(32), .DATA_WIDTH(16), .DATA_WIDTH_ACC(32)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .element_valid(element_valid), .element_start(element_start), .element_last(element_last),
    .element_a(element_a[31:0]), .element_b(element_b[31:0]),
    .vctr_ref(vctr_ref), .band_shift(band_shift),
    .mse_valid(s_valid), .mse_value(s_value), .mse_ref(s_ref),
    .proto_err(s_err), .busy(s_busy)
  );

  typedef struct {
    logic [7:0]  r;
    logic [63:0] v;
    int          c;
  } res_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  res_t        got_q[$];
  res_t        exp_q[$];
  logic [31:0] sat_q[$];
  logic [63:0] va[16], vb[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mse_valid) got_q.push_back('{mse_ref, mse_value, cyc});
      if (proto_err) err_cnt++;
      if (s_valid)   sat_q.push_back(s_value);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sum of per-lane squared differences over va/vb[0..n-1], each lane clamped
  // at 2^48-1, divided by 2^sh.
  function automatic logic [63:0] model_mse(input int n, input int sh);
    longint unsigned total, acc, d;
    int unsigned x, y;
    total = 0;
    for (int l = 0; l < 4; l++) begin
      acc = 0;
      for (int e = 0; e < n; e++) begin
        x = 32'(va[e][l*16 +: 16]);
        y = 32'(vb[e][l*16 +: 16]);
        d = (x > y) ? longint'(x - y) : longint'(y - x);
        acc = acc + d * d;
        if (acc > 64'hFFFF_FFFF_FFFF) acc = 64'hFFFF_FFFF_FFFF;
      end
      total = total + acc;
    end
`ifdef MSE_MULTI_ROUND_EN
    if (sh != 0) total = total + (64'd1 << (sh - 1));
`endif
    return total >> sh;
  endfunction

  task automatic drive(input logic v, input logic s, input logic l,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [7:0] r, input logic [3:0] sh, output int edge_n);
    element_valid = v; element_start = s; element_last = l;
    element_a = a; element_b = b; vctr_ref = r; band_shift = sh;
    @(posedge clk);
    #1;
    edge_n = cyc;
  endtask

  task automatic idle(input int n);
    int en;
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, en);
  endtask

  // Plays va/vb[0..n-1] as one vector; ref/shift on later elements are junk.
  task automatic send_vector(input int n, input logic [7:0] r, input logic [3:0] sh,
                             input int gap_pct, output int last_edge);
    int en;
    for (int e = 0; e < n; e++) begin
      if (e != 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 2));
      drive(1'b1, e == 0, e == n - 1, va[e], vb[e],
            (e == 0) ? r : 8'($urandom), (e == 0) ? sh : 4'($urandom), en);
    end
    last_edge = en;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (mse_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mse_valid got=%0b exp=0", mse_valid); end
    vectors++; if (mse_value !== 64'd0) begin miscompares++; $display("FAIL reset_mse_value got=%0h exp=0", mse_value); end
    vectors++; if (mse_ref !== 8'd0) begin miscompares++; $display("FAIL reset_mse_ref got=%0h exp=0", mse_ref); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    int le;
    got_q.delete(); err_cnt = 0;
    for (int e = 0; e < 4; e++) begin va[e] = {4{16'd10}}; vb[e] = {4{16'd7}}; end
    send_vector(4, 8'h5A, 4'd2, 0, le);
    idle(8);
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++; $display("FAIL basic_count got=%0d exp=1", got_q.size());
    end else begin
      vectors++; if (got_q[0].v !== 64'd36) begin miscompares++; $display("FAIL basic_value got=%0d exp=36", got_q[0].v); end
      vectors++; if (got_q[0].r !== 8'h5A) begin miscompares++; $display("FAIL basic_ref got=%0h exp=5a", got_q[0].r); end
      vectors++; if (got_q[0].c - le !== 4) begin miscompares++; $display("FAIL basic_latency got=%0d exp=4", got_q[0].c - le); end
    end
  endtask

  task automatic test_back_to_back;
    int le0, le1;
    got_q.delete(); err_cnt = 0;
    va[0] = {16'h1234, 16'h1234, 16'h1234, 16'd5};
    vb[0] = {16'h1234, 16'h1234, 16'h1234, 16'd0};
    send_vector(1, 8'd1, 4'd0, 0, le0);
    send_vector(1, 8'd2, 4'd0, 0, le1);
    idle(8);
    vectors++;
    if (got_q.size() !== 2) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=2", got_q.size());
    end else begin
      vectors++; if (got_q[0].v !== 64'd25 || got_q[1].v !== 64'd25) begin miscompares++; $display("FAIL b2b_value got=%0d,%0d exp=25,25", got_q[0].v, got_q[1].v); end
      vectors++; if (got_q[0].r !== 8'd1 || got_q[1].r !== 8'd2) begin miscompares++; $display("FAIL b2b_ref got=%0d,%0d exp=1,2", got_q[0].r, got_q[1].r); end
      vectors++; if (got_q[0].c - le0 !== 4) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=4", got_q[0].c - le0); end
      vectors++; if (got_q[1].c - got_q[0].c !== 1) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=1", got_q[1].c - got_q[0].c); end
    end
    vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL b2b_proto_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_abort;
    int en;
    logic [63:0] expv;
    got_q.delete(); err_cnt = 0;
    drive(1'b1, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 8'd3, 4'd1, en);
    drive(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 8'd3, 4'd1, en);
    for (int e = 0; e < 3; e++) begin va[e] = {$urandom, $urandom}; vb[e] = {$urandom, $urandom}; end
    expv = model_mse(3, 1);
    drive(1'b1, 1'b1, 1'b0, va[0], vb[0], 8'd4, 4'd1, en);
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL abort_err_pulse got=%0b exp=1", proto_err); end
    drive(1'b1, 1'b0, 1'b0, va[1], vb[1], 8'd9, 4'd7, en);
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL abort_err_width got=%0b exp=0", proto_err); end
    drive(1'b1, 1'b0, 1'b1, va[2], vb[2], 8'd9, 4'd7, en);
    idle(8);
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL abort_err_count got=%0d exp=1", err_cnt); end
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++; $display("FAIL abort_count got=%0d exp=1", got_q.size());
    end else begin
      vectors++; if (got_q[0].r !== 8'd4) begin miscompares++; $display("FAIL abort_ref got=%0d exp=4", got_q[0].r); end
      vectors++; if (got_q[0].v !== expv) begin miscompares++; $display("FAIL abort_value got=%0h exp=%0h", got_q[0].v, expv); end
    end
  endtask

  task automatic test_drop;
    int en, busy_hits;
    got_q.delete(); err_cnt = 0; busy_hits = 0;
    drive(1'b1, 1'b0, 1'b1, {4{16'd9}}, '0, 8'd7, 4'd0, en);
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL drop_err_pulse got=%0b exp=1", proto_err); end
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0) busy_hits++;
      idle(1);
    end
    vectors++; if (busy_hits !== 0) begin miscompares++; $display("FAIL drop_busy got=%0d busy cycles exp=0", busy_hits); end
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL drop_result got=%0d strobes exp=0", got_q.size()); end
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL drop_err_count got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_round;
    int le;
    logic [63:0] expv;
    got_q.delete();
    va[0] = {16'd1, 16'd1, 16'd1, 16'd2};
    vb[0] = '0;
`ifdef MSE_MULTI_ROUND_EN
    expv = 64'd4;
`else
    expv = 64'd3;
`endif
    send_vector(1, 8'd11, 4'd1, 0, le);
    idle(8);
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++; $display("FAIL round_count got=%0d exp=1", got_q.size());
    end else begin
      vectors++; if (got_q[0].v !== expv) begin miscompares++; $display("FAIL round_value got=%0d exp=%0d", got_q[0].v, expv); end
    end
  endtask

  task automatic test_saturation;
    int le;
    logic [31:0] exp_sh4;
`ifdef MSE_MULTI_ROUND_EN
    exp_sh4 = 32'h2000_0000;
`else
    exp_sh4 = 32'h1FFF_FFFF;
`endif
    sat_q.delete();
    for (int e = 0; e < 4; e++) begin va[e] = '1; vb[e] = '0; end
    send_vector(4, 8'd9, 4'd0, 0, le);
    send_vector(4, 8'd9, 4'd4, 0, le);
    idle(8);
    vectors++;
    if (sat_q.size() !== 2) begin
      miscompares++; $display("FAIL sat_count got=%0d exp=2", sat_q.size());
    end else begin
      vectors++; if (sat_q[0] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sat_word got=%0h exp=ffffffff", sat_q[0]); end
      vectors++; if (sat_q[1] !== exp_sh4) begin miscompares++; $display("FAIL sat_lane_acc got=%0h exp=%0h", sat_q[1], exp_sh4); end
    end
  endtask

  task automatic test_random;
    int le, n, sh;
    logic [7:0] r;
    got_q.delete(); exp_q.delete(); err_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      n  = $urandom_range(1, 6);
      sh = $urandom_range(0, 9);
      r  = 8'($urandom);
      for (int e = 0; e < n; e++) begin va[e] = {$urandom, $urandom}; vb[e] = {$urandom, $urandom}; end
      send_vector(n, r, 4'(sh), 30, le);
      exp_q.push_back('{r, model_mse(n, sh), le + 4});
      if ($urandom_range(1) == 1) idle($urandom_range(1, 2));
    end
    idle(8);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++; if (got_q[i].r !== exp_q[i].r) begin miscompares++; $display("FAIL rand_ref[%0d] got=%0h exp=%0h", i, got_q[i].r, exp_q[i].r); end
        vectors++; if (got_q[i].v !== exp_q[i].v) begin miscompares++; $display("FAIL rand_value[%0d] got=%0h exp=%0h", i, got_q[i].v, exp_q[i].v); end
        vectors++; if (got_q[i].c !== exp_q[i].c) begin miscompares++; $display("FAIL rand_timing[%0d] got=%0d exp=%0d", i, got_q[i].c, exp_q[i].c); end
      end
    end
    vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL rand_proto_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_mid;
    int en;
    got_q.delete();
    drive(1'b1, 1'b1, 1'b0, {4{16'd100}}, '0, 8'd21, 4'd0, en);
    drive(1'b1, 1'b0, 1'b0, {4{16'd100}}, '0, 8'd21, 4'd0, en);
    drive(1'b1, 1'b0, 1'b1, {4{16'd100}}, '0, 8'd21, 4'd0, en);
    element_valid = 1'b0; element_start = 1'b0; element_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mse_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_mse_valid got=%0b exp=0", mse_valid); end
    vectors++; if (mse_value !== 64'd0) begin miscompares++; $display("FAIL rstmid_mse_value got=%0h exp=0", mse_value); end
    vectors++; if (mse_ref !== 8'd0) begin miscompares++; $display("FAIL rstmid_mse_ref got=%0h exp=0", mse_ref); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_proto_err got=%0b exp=0", proto_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(8);
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL rstmid_result got=%0d strobes exp=0", got_q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_after got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_abort;
    test_drop;
    test_round;
    test_saturation;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
